// File: rtl/crypto_cmd_initiator_if.sv
// ============================================================================
// Module      : crypto_cmd_initiator_if
// Description : Bundles the CPU register port and the accelerator command
//               port of crypto_cmd_initiator. The master modport is the
//               initiator's view; slave is the CPU/accelerator side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface crypto_cmd_initiator_if;
    // CPU register port
    logic         wr_en;
    logic [5:0]   wr_addr;
    logic [7:0]   wr_data;
    logic         rd_en;
    logic [5:0]   rd_addr;
    logic [7:0]   rd_data;
    logic         irq;
    // Accelerator command port
    logic         acc_enable;
    logic [3:0]   acc_operation;
    logic [127:0] acc_data_in;
    logic [127:0] acc_key;
    logic [127:0] acc_data_out;
    logic         acc_done;
    logic         acc_error;

    modport master (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output rd_data, irq,
        output acc_enable, acc_operation, acc_data_in, acc_key,
        input  acc_data_out, acc_done, acc_error
    );

    modport slave (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_data, irq,
        input  acc_enable, acc_operation, acc_data_in, acc_key,
        output acc_data_out, acc_done, acc_error
    );
endinterface

`default_nettype wire

// File: rtl/crypto_cmd_initiator.sv
// ============================================================================
// Module      : crypto_cmd_initiator
// Description : CPU-side initiator for the crypto accelerator. Stages a
//               16-byte block and key from byte register writes, issues a
//               one-cycle start, waits for done/error with a timeout,
//               captures the result and raises a level interrupt.
//               Optional macro CRYPTO_INIT_KEY_WIPE_EN: zero the staged key
//               whenever a command leaves WAIT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crypto_cmd_initiator #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_W           = 8
) (
    input  wire logic               clk,
    input  wire logic               rst,
    crypto_cmd_initiator_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [7:0]      r_data   [16];
    logic [7:0]      r_key    [16];
    logic [7:0]      r_result [16];
    logic [3:0]      r_op;
    logic            r_done_st;
    logic            r_err_st;
    logic            r_to_st;
    logic            r_rej_st;
    logic [TO_W-1:0] r_timer;
    logic [7:0]      r_rd_data;
    logic [7:0]      w_rd_mux;

    logic w_busy, w_wr_data, w_wr_key, w_wr_cmd, w_wr_stat;
    logic w_start, w_reject, w_fin_done, w_fin_err, w_fin_to, w_leave;

    assign w_busy     = (r_state != ST_IDLE);
    assign w_wr_data  = bus.wr_en && (bus.wr_addr[5:4] == 2'b00);
    assign w_wr_key   = bus.wr_en && (bus.wr_addr[5:4] == 2'b01);
    assign w_wr_cmd   = bus.wr_en && (bus.wr_addr == 6'h20);
    assign w_wr_stat  = bus.wr_en && (bus.wr_addr == 6'h21);
    assign w_start    = w_wr_cmd && !w_busy && bus.wr_data[7];
    assign w_reject   = w_busy && (w_wr_data || w_wr_key || w_wr_cmd);

    // Completion events only count in WAIT; error beats done, any pulse beats timeout.
    assign w_fin_err  = (r_state == ST_WAIT) && bus.acc_error;
    assign w_fin_done = (r_state == ST_WAIT) && bus.acc_done && !bus.acc_error;
    assign w_fin_to   = (r_state == ST_WAIT) && !bus.acc_done && !bus.acc_error
                        && (r_timer == c_TO_LAST);
    assign w_leave    = w_fin_err || w_fin_done || w_fin_to;

    assign bus.acc_enable    = (r_state == ST_ISSUE);
    assign bus.acc_operation = r_op;
    assign bus.irq           = r_done_st | r_err_st;
    assign bus.rd_data       = r_rd_data;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_pack
            assign bus.acc_data_in[8*gi +: 8] = r_data[gi];
            assign bus.acc_key[8*gi +: 8]     = r_key[gi];
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic: IDLE -> ISSUE on start, one ISSUE cycle, WAIT until an outcome.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_start) w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT:  if (w_leave) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // WAIT-cycle timer, restarted on every accepted start.
    always_ff @(posedge clk) begin
        if (rst)                                  r_timer <= '0;
        else if (w_start)                         r_timer <= '0;
        else if ((r_state == ST_WAIT) && !w_leave) r_timer <= r_timer + 1'b1;
    end

    // DATA/KEY staging; writes only land while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                r_data[i] <= '0;
                r_key[i]  <= '0;
            end
        end else begin
            if (w_wr_data && !w_busy) r_data[bus.wr_addr[3:0]] <= bus.wr_data;
            if (w_wr_key && !w_busy)  r_key[bus.wr_addr[3:0]]  <= bus.wr_data;
`ifdef CRYPTO_INIT_KEY_WIPE_EN
            if (w_leave) begin
                for (int i = 0; i < 16; i++) r_key[i] <= '0;
            end
`endif
        end
    end

    // Result capture on a clean done only.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) r_result[i] <= '0;
        end else if (w_fin_done) begin
            for (int i = 0; i < 16; i++) r_result[i] <= bus.acc_data_out[8*i +: 8];
        end
    end

    // Opcode latch and sticky status; a setting event overrides a same-cycle W1C.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= '0;
            r_done_st <= 1'b0;
            r_err_st  <= 1'b0;
            r_to_st   <= 1'b0;
            r_rej_st  <= 1'b0;
        end else begin
            if (w_wr_cmd && !w_busy) r_op <= bus.wr_data[3:0];
            r_done_st <= (r_done_st & ~(w_wr_stat & bus.wr_data[1]) & ~w_start) | w_fin_done;
            r_err_st  <= (r_err_st  & ~(w_wr_stat & bus.wr_data[2]) & ~w_start) | w_fin_err | w_fin_to;
            r_to_st   <= (r_to_st   & ~(w_wr_stat & bus.wr_data[3]) & ~w_start) | w_fin_to;
            r_rej_st  <= (r_rej_st  & ~(w_wr_stat & bus.wr_data[4])) | w_reject;
        end
    end

    // Register read decode.
    always_comb begin
        w_rd_mux = 8'h00;
        case (bus.rd_addr[5:4])
            2'b00: w_rd_mux = r_data[bus.rd_addr[3:0]];
            2'b01: w_rd_mux = r_key[bus.rd_addr[3:0]];
            2'b11: w_rd_mux = r_result[bus.rd_addr[3:0]];
            default: begin
                if (bus.rd_addr == 6'h20)      w_rd_mux = {4'b0000, r_op};
                else if (bus.rd_addr == 6'h21) w_rd_mux = {3'b000, r_rej_st, r_to_st,
                                                            r_err_st, r_done_st, w_busy};
            end
        endcase
    end

    // Read data register, one cycle after the strobe.
    always_ff @(posedge clk) begin
        if (rst)             r_rd_data <= '0;
        else if (bus.rd_en)  r_rd_data <= w_rd_mux;
    end

endmodule

`default_nettype wire
